// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment scan controller: one shared hex decoder, guard gap between digits,
// and frame-aligned display updates. Optional leading-zero blanking via LEADING_ZERO_BLANK_EN.
module seven_segment_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          scan_en,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic [NUM_DIGITS-1:0]         load_blank,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic [3:0]                    hex_out,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  typedef enum logic {ST_GUARD, ST_SHOW} state_e;

  localparam int unsigned MAXC = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned IW   = $clog2(NUM_DIGITS);

  localparam state_e         ST_START   = (GUARD_CYCLES == 0) ? ST_SHOW : ST_GUARD;
  localparam logic [CW-1:0]  SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    ready_q, ready_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    boundary;
  logic                    promote;

  always_comb begin
    lz_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lz_run;
      lz_run = 1'b1;
      // Walk from the most significant digit down; digit 0 is never touched.
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (lz_run && (pend_data_q[4*i +: 4] == 4'h0)) lz_mask[i] = 1'b1;
        else lz_run = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    disp_d       = disp_q;
    blank_d      = blank_q;
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    ready_d      = ready_q;
    boundary     = 1'b0;

    if (!scan_en) begin
      state_d = ST_START;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_START;
            cnt_d   = '0;
            if (idx_q == LAST_IDX) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      endcase
    end

    frame_done_d = boundary;

    // Disabling the scan counts as a frame boundary so a pending word never waits on a dark display.
    promote = (boundary || !scan_en) && !ready_q;
    if (promote) begin
      disp_d  = pend_data_q;
      blank_d = pend_blank_q | lz_mask;
      ready_d = 1'b1;
    end else if (load_valid && ready_q) begin
      pend_data_d  = load_data;
      pend_blank_d = load_blank;
      ready_d      = 1'b0;
    end

    // Outputs are registered, so they are derived from the next-state values.
    an_d = '1;
    if (scan_en && (state_d == ST_SHOW) && !blank_d[idx_d]) an_d[idx_d] = 1'b0;
    hex_d = disp_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_START;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      blank_q      <= '0;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      hex_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      blank_q      <= blank_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
    end
  end

  assign load_ready = ready_q;
  assign hex_out    = hex_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: cycle-position reference model plus directed frame checks.
module tb_seven_segment_scan_controller;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int SLOT  = G + R;
  localparam int FRAME = N * SLOT;

  logic         clk;
  logic         rst_n;
  logic         scan_en;
  logic [15:0]  load_data;
  logic [3:0]   load_blank;
  logic         load_valid;
  logic         load_ready;
  logic [3:0]   hex_out;
  logic [3:0]   an;
  logic [1:0]   digit_idx;
  logic         frame_done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  seven_segment_scan_controller #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .GUARD_CYCLES(G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .load_data (load_data),
    .load_blank(load_blank),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .hex_out   (hex_out),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Leading-zero mask: every digit above the highest nonzero nibble (digit 0 excluded).
  function automatic logic [3:0] lz(input logic [15:0] w);
    logic [3:0] m;
    m = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < N; i++) if (w[4*i +: 4] != 4'h0) hi = i;
      for (int i = 1; i < N; i++) if (i > hi) m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  // Reference model: position within the scan since the last restart, plus display/pending words.
  int          m_pos;
  logic [15:0] m_disp, m_pdata;
  logic [3:0]  m_blank, m_pblank;
  logic        m_ready, m_fd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos   = 0;
      m_disp  = '0;
      m_blank = '0;
      m_ready = 1'b1;
      m_fd    = 1'b0;
    end else begin
      bit at_end;
      at_end = (m_pos % FRAME) == FRAME - 1;
      m_fd   = scan_en && at_end;
      if ((!scan_en || at_end) && !m_ready) begin
        m_disp  = m_pdata;
        m_blank = m_pblank | lz(m_pdata);
        m_ready = 1'b1;
      end else if (load_valid && m_ready) begin
        m_pdata  = load_data;
        m_pblank = load_blank;
        m_ready  = 1'b0;
      end
      m_pos = scan_en ? m_pos + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int digit, phase;
      logic [3:0] exp_an;
      digit  = (m_pos / SLOT) % N;
      phase  = m_pos % SLOT;
      exp_an = 4'hF;
      if (phase >= G && !m_blank[digit]) exp_an[digit] = 1'b0;
      check("model_an", an, exp_an);
      check("model_hex", hex_out, m_disp[4*digit +: 4]);
      check("model_idx", digit_idx, digit);
      check("model_frame_done", frame_done, m_fd);
      check("model_ready", load_ready, m_ready);
      check("an_one_cold", ($countones(~an) <= 1), 1);
    end
  end

  task automatic reset_literals();
    check("rst_an", an, 4'hF);
    check("rst_hex", hex_out, 4'h0);
    check("rst_idx", digit_idx, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ready", load_ready, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] b);
    int n;
    n          = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_blank = b;
    while (!load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", load_ready, 1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait", frame_done, 1);
  endtask

  // Called on the frame_done cycle; checks one whole frame against a hand-built pattern.
  task automatic check_frame(input logic [15:0] w, input logic [3:0] bl);
    for (int k = 0; k < FRAME; k++) begin
      int d, ph;
      logic [3:0] ea;
      d  = k / SLOT;
      ph = k % SLOT;
      ea = 4'hF;
      if (ph != 0 && !bl[d]) ea[d] = 1'b0;
      check("frame_an", an, ea);
      check("frame_hex", hex_out, w[4*d +: 4]);
      check("frame_pulse", frame_done, (k == 0));
      if (k < FRAME - 1) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    scan_en    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_blank = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    reset_literals();

    rst_n   = 1'b1;
    scan_en = 1'b1;
    send(16'h1234, 4'b0000);
    check("ready_low_pending", load_ready, 0);

    // Second word held on the bus while the first is still pending.
    load_valid = 1'b1;
    load_data  = 16'hABCD;
    load_blank = 4'b0000;
    wait_frame();
    check_frame(16'h1234, 4'b0000);
    load_valid = 1'b0;
    wait_frame();
    check_frame(16'hABCD, 4'b0000);

    // Transfer on the boundary cycle: captured now, shown one frame later.
    send(16'h5678, 4'b0100);
    check("boundary_capture_ready", load_ready, 0);
    check("boundary_capture_pulse", frame_done, 1);
    check_frame(16'hABCD, 4'b0000);
    wait_frame();
    check_frame(16'h5678, 4'b0100);

    // scan_en dropped mid-SHOW of digit 2 with a word pending.
    send(16'h0F0F, 4'b0000);
    n = 0;
    while (digit_idx != 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_digit2", digit_idx, 2);
    @(negedge clk);
    @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    check("drop_an", an, 4'hF);
    check("drop_idx", digit_idx, 0);
    check("drop_ready", load_ready, 1);
    check("drop_hex", hex_out, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("drop_no_pulse", frame_done, 0);
    end
    scan_en = 1'b1;
    check("reen_guard_an", an, 4'hF);
    @(negedge clk);
    check("reen_show_an", an, 4'hE);
    check("reen_show_hex", hex_out, 4'hF);
    wait_frame();
    check_frame(16'h0F0F, 4'b0000);

    // Reset mid-frame discards a pending word.
    send(16'h1111, 4'b0000);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    reset_literals();
    rst_n = 1'b1;
    wait_frame();
    check_frame(16'h0000, 4'b0000);

`ifdef LEADING_ZERO_BLANK_EN
    @(negedge clk);
    send(16'h0050, 4'b0000);
    wait_frame();
    check_frame(16'h0050, 4'b1100);
    @(negedge clk);
    send(16'h0000, 4'b0000);
    wait_frame();
    check_frame(16'h0000, 4'b1110);
`endif

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
